// File: rtl/sort_out_serializer_pkg.sv
// Shared definitions for the sorter output serializer.
// Holds the default geometry (element width, lanes per beat, batch size),
// the derived beat count and index width, the read-FSM state type, and a
// helper that extracts the k-th W-bit lane from a packed sorter beat.
package sort_out_serializer_pkg;

    localparam int SOS_W     = 6;
    localparam int SOS_P     = 16;
    localparam int SOS_N     = 32;
    localparam int SOS_BEATS = SOS_N / SOS_P;
    localparam int SOS_IW    = $clog2(SOS_N);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rd_state_e;

    // Lane k of a packed beat; lane 0 (DO1) sits in the least significant bits.
    function automatic logic [SOS_W-1:0] lane_slice(input logic [SOS_P*SOS_W-1:0] bus,
                                                    input int unsigned k);
        return bus[k*SOS_W +: SOS_W];
    endfunction

endpackage

// File: rtl/sort_out_serializer_beat_buf.sv
// sort_beat_buf: two-slot ping-pong store for sorter beats.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   wr_en, wr_data    beat presented by the sorter (already gated by valid && en)
//   rd_free           release the slot at rd_ptr this edge
//   rd_lane, rd_data  lane select into the slot at rd_ptr
//   occ, occ_next     current occupancy and the value it takes at the next edge
//   overflow          sticky: a beat was presented while both slots were full
module sort_beat_buf
    import sort_out_serializer_pkg::*;
#(
    parameter int W  = SOS_W,
    parameter int P  = SOS_P,
    parameter int LW = (P > 1) ? $clog2(P) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [P*W-1:0] wr_data,
    input  logic          rd_free,
    input  logic [LW-1:0] rd_lane,
    output logic [W-1:0]  rd_data,
    output logic [1:0]    occ,
    output logic [1:0]    occ_next,
    output logic          overflow
);

    logic [P*W-1:0] slot_q [2];
    logic [P*W-1:0] slot_d [2];
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [1:0]     occ_q, occ_d;
    logic           overflow_q, overflow_d;
    logic           full;
    logic           wr_ok;

    // Room is judged on the occupancy before the edge, so a slot released
    // on the same edge never admits a beat that arrives while full.
    assign full  = (occ_q == 2'd2);
    assign wr_ok = wr_en && !full;

    always_comb begin
        slot_d     = slot_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        overflow_d = overflow_q;

        if (wr_ok) begin
            slot_d[wr_ptr_q] = wr_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (rd_free) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({wr_ok, rd_free})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q[0]  <= '0;
            slot_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
        end
    end

    assign rd_data  = slot_q[rd_ptr_q][W*rd_lane +: W];
    assign occ      = occ_q;
    assign occ_next = occ_d;
    assign overflow = overflow_q;

endmodule

// File: rtl/sort_out_serializer.sv
// sort_out_serializer: captures P-lane sorter beats into a ping-pong buffer
// and drains them one element per cycle over a valid/ready stream, tagging
// the first and last element of each N-element batch.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   sin_valid, sin_en, sin_data   sorter Vout, ENout and packed lanes
//   dout, dout_valid, dout_ready  element stream with handshake
//   dout_first, dout_last         element index 0 / N-1 of the batch
//   dout_idx                      element index within the batch
//   overflow                      sticky beat-dropped flag
//   busy                          buffer holds at least one beat
//
// state    | meaning
// ST_IDLE  | no beat being streamed, dout_valid low
// ST_SHIFT | streaming lanes of slot[rd_ptr], dout_valid high
module sort_out_serializer
    import sort_out_serializer_pkg::*;
#(
    parameter int W  = SOS_W,
    parameter int P  = SOS_P,
    parameter int N  = SOS_N,
    parameter int IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sin_valid,
    input  logic           sin_en,
    input  logic [P*W-1:0] sin_data,
    output logic [W-1:0]   dout,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic           dout_first,
    output logic           dout_last,
    output logic [IW-1:0]  dout_idx,
    output logic           overflow,
    output logic           busy
);

    localparam int BEATS = N / P;
    localparam int LW    = (P > 1) ? $clog2(P) : 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    rd_state_e     state_q, state_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic          rd_free;
    logic [W-1:0]  rd_data;
    logic [1:0]    occ;
    logic [1:0]    occ_next;

    sort_beat_buf #(
        .W  (W),
        .P  (P),
        .LW (LW)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (sin_valid && sin_en),
        .wr_data  (sin_data),
        .rd_free  (rd_free),
        .rd_lane  (lane_q),
        .rd_data  (rd_data),
        .occ      (occ),
        .occ_next (occ_next),
        .overflow (overflow)
    );

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        beat_cnt_d = beat_cnt_q;
        rd_free    = 1'b0;
        dout_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (occ != 2'd0) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                dout_valid = 1'b1;
                if (dout_ready) begin
                    if (lane_q == LW'(P-1)) begin
                        lane_d     = '0;
                        rd_free    = 1'b1;
                        beat_cnt_d = (beat_cnt_q == BW'(BEATS-1)) ? '0 : beat_cnt_q + 1'b1;
                        // A beat captured on this same edge keeps the stream
                        // going without a bubble.
                        if (occ_next == 2'd0) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            lane_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign dout_idx   = IW'(beat_cnt_q) * IW'(P) + IW'(lane_q);
    assign dout       = dout_valid ? rd_data : '0;
    assign dout_first = dout_valid && (dout_idx == '0);
    assign dout_last  = dout_valid && (dout_idx == IW'(N-1));
    assign busy       = (occ != 2'd0);

endmodule
